// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_seq_pkg;

   typedef enum logic [1:0] {
      MODE_COUNT  = 2'd0,
      MODE_CHASE  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

   localparam int SPEED_MAX = 3;
   localparam int SEED_W    = 64;

   // Pattern loaded on a mode change; callers truncate to their width (n <= SEED_W).
   function automatic logic [SEED_W-1:0] seed(mode_t m, int unsigned n);
      case (m)
         MODE_COUNT: seed = '0;
         MODE_BLINK: seed = (SEED_W'(1) << n) - SEED_W'(1);
         default:    seed = SEED_W'(1);
      endcase
   endfunction

endpackage

// File: rtl/led_seq_if.sv
// Control inputs and display outputs of the LED sequencer.
interface led_seq_if
   import led_seq_pkg::*;
#(
   parameter int N_LEDS = 8
);
   logic [1:0]                       mode_i;
   logic [$clog2(SPEED_MAX+1)-1:0]   speed_i;
   logic                             pause_i;
   logic                             step_i;
   logic [N_LEDS-1:0]                led_o;
   logic                             tick_o;

   modport master (output mode_i, speed_i, pause_i, step_i, input led_o, tick_o);
   modport slave  (input mode_i, speed_i, pause_i, step_i, output led_o, tick_o);
endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: one tick every (BASE_PERIOD >> speed_i) enabled cycles.
module led_tick_gen
   import led_seq_pkg::*;
#(
   parameter int BASE_PERIOD = 50000000
) (
   input  logic                           CLK50MHZ,
   input  logic                           reset,
   input  logic                           en,
   input  logic                           restart,
   input  logic [$clog2(SPEED_MAX+1)-1:0] speed_i,
   output logic                           tick_o
);
   localparam int CW = $clog2(BASE_PERIOD);

   logic [CW-1:0] cnt;
   logic [CW-1:0] last;
   logic          at_end;

   assign last   = CW'((BASE_PERIOD >> speed_i) - 1);
   // >= so a speed-up past the current count fires immediately instead of wrapping
   assign at_end = (cnt >= last);
   assign tick_o = en & ~restart & at_end;

   always_ff @(posedge CLK50MHZ) begin
      if (reset || restart)
         cnt <= '0;
      else if (en)
         cnt <= at_end ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: four display modes advanced by a prescaled tick or a manual step.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1,
   parameter int N_LEDS  = 8
) (
   input  logic      CLK50MHZ,
   input  logic      reset,
   led_seq_if.slave  bus
);
   localparam int BASE_PERIOD = CLK_HZ / TICK_HZ;
   localparam logic [N_LEDS-1:0] MSB_ONLY = {1'b1, {(N_LEDS-1){1'b0}}};
   localparam logic [N_LEDS-1:0] LSB_ONLY = N_LEDS'(1);

   mode_t             mode_r, mode_n, mode_in;
   dir_t              dir_r, dir_n;
   logic [N_LEDS-1:0] led_r, led_n;
   logic              tick_r, tick_n;
   logic              tick, adv, mode_chg;

   assign mode_in  = mode_t'(bus.mode_i);
   assign mode_chg = (mode_in != mode_r);
   assign adv      = (tick & ~bus.pause_i) | (bus.step_i & bus.pause_i);

   led_tick_gen #(.BASE_PERIOD(BASE_PERIOD)) u_tick (
      .CLK50MHZ (CLK50MHZ),
      .reset    (reset),
      .en       (~bus.pause_i),
      .restart  (mode_chg),
      .speed_i  (bus.speed_i),
      .tick_o   (tick)
   );

   always_comb begin
      mode_n = mode_r;
      dir_n  = dir_r;
      led_n  = led_r;
      tick_n = 1'b0;
      if (mode_chg) begin
         mode_n = mode_in;
         led_n  = N_LEDS'(seed(mode_in, N_LEDS));
         dir_n  = DIR_LEFT;
      end else if (adv) begin
         tick_n = 1'b1;
         unique case (mode_r)
            MODE_COUNT: led_n = led_r + 1'b1;
            MODE_CHASE: led_n = {led_r[N_LEDS-2:0], led_r[N_LEDS-1]};
            MODE_BOUNCE: begin
               // turn around as soon as an end is reached so endpoints show once
               if (dir_r == DIR_LEFT) begin
                  led_n = led_r << 1;
                  if (led_n == MSB_ONLY) dir_n = DIR_RIGHT;
               end else begin
                  led_n = led_r >> 1;
                  if (led_n == LSB_ONLY) dir_n = DIR_LEFT;
               end
            end
            MODE_BLINK: led_n = ~led_r;
         endcase
      end
   end

   always_ff @(posedge CLK50MHZ) begin
      if (reset) begin
         mode_r <= MODE_COUNT;
         dir_r  <= DIR_LEFT;
         led_r  <= '1;
         tick_r <= 1'b0;
      end else begin
         mode_r <= mode_n;
         dir_r  <= dir_n;
         led_r  <= led_n;
         tick_r <= tick_n;
      end
   end

   assign bus.led_o  = led_r;
   assign bus.tick_o = tick_r;
endmodule
